apb_requester: RTL and testbench



---
 rtl/apb_pkg.sv | 21 ++
 rtl/apb_addr_decode.sv | 32 +++
 rtl/apb_requester.sv | 160 ++++++++++++++++
 tb/tb_apb_requester.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB requester types: FSM state encoding, default bus widths and PPROT bit masks.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DERR
  } apb_state_e;

  localparam int unsigned APB_ADDR_W  = 32;
  localparam int unsigned APB_DATA_W  = 32;
  localparam int unsigned APB_NSLV    = 4;
  localparam int unsigned APB_SLV_LSB = 28;
  localparam int unsigned APB_TIMEOUT = 16;

  localparam logic [2:0] PPROT_PRIV      = 3'b001;
  localparam logic [2:0] PPROT_NONSECURE = 3'b010;
  localparam logic [2:0] PPROT_INSTR     = 3'b100;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational completer decode: one-hot select from the address index field, plus an
// out-of-range flag. Shared with the interconnect.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned NSLV    = APB_NSLV,
  parameter int unsigned SLV_LSB = APB_SLV_LSB
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NSLV-1:0]   sel,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(NSLV);

  logic [IDX_W-1:0] idx;
  logic             unused_addr;

  // Only the index field matters; the remaining address bits are deliberately ignored.
  assign unused_addr = ^addr;

  always_comb begin
    idx = addr[SLV_LSB +: IDX_W];
    err = ({{(32 - IDX_W){1'b0}}, idx} >= NSLV);
    sel = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      sel[i] = !err && (idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/apb_requester.sv
// APB4 requester: valid/ready command stream to APB SETUP/ACCESS transfers with a registered
// single-cycle response. Optional ACCESS wait limit enabled by defining APB_TIMEOUT_EN.
module apb_requester
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned NSLV    = APB_NSLV,
  parameter int unsigned SLV_LSB = APB_SLV_LSB,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  input  logic [2:0]            cmd_prot,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [NSLV-1:0]       psel,
  output logic                  penable,
  output logic [ADDR_W-1:0]     paddr,
  output logic                  pwrite,
  output logic [2:0]            pprot,
  output logic [DATA_W-1:0]     pwdata,
  output logic [DATA_W/8-1:0]   pstrb,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  if (NSLV < 2 || TIMEOUT < 1) begin : g_cfg_check
    $error("apb_requester: NSLV must be >= 2 and TIMEOUT >= 1");
  end

  apb_state_e      state_q, state_d;
  logic [NSLV-1:0] dec_sel;
  logic            dec_err;
  logic            accept;
  logic            tmo_hit;

  apb_addr_decode #(
    .ADDR_W  (ADDR_W),
    .NSLV    (NSLV),
    .SLV_LSB (SLV_LSB)
  ) u_decode (
    .addr (cmd_addr),
    .sel  (dec_sel),
    .err  (dec_err)
  );

  assign cmd_ready = preset && ((state_q == IDLE) || ((state_q == ACCESS) && pready));
  assign accept    = cmd_valid && cmd_ready;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_cnt;

  // A late pready on the limit cycle still completes normally.
  assign tmo_hit = (state_q == ACCESS) && !pready && (tmo_cnt == TMO_W'(TIMEOUT - 1));

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      tmo_cnt <= '0;
    end else if (state_q == SETUP) begin
      tmo_cnt <= '0;
    end else if ((state_q == ACCESS) && !pready) begin
      tmo_cnt <= tmo_cnt + TMO_W'(1);
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = dec_err ? DERR : SETUP;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (accept) state_d = dec_err ? DERR : SETUP;
          else        state_d = IDLE;
        end else if (tmo_hit) begin
          state_d = IDLE;
        end
      end
      DERR:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response fields default to zero so they only carry data during the rsp_valid pulse.
  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      psel      <= '0;
      penable   <= 1'b0;
      paddr     <= '0;
      pwrite    <= 1'b0;
      pprot     <= '0;
      pwdata    <= '0;
      pstrb     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      case (state_q)
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (pready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= (!pwrite && !pslverr) ? prdata : '0;
            psel      <= '0;
            penable   <= 1'b0;
          end else if (tmo_hit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            psel      <= '0;
            penable   <= 1'b0;
          end
        end
        DERR: begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
        end
        default: ;
      endcase
      // A back-to-back acceptance overrides the idle-return above.
      if (accept) begin
        psel    <= dec_sel;
        penable <= 1'b0;
        paddr   <= cmd_addr;
        pwrite  <= cmd_write;
        pprot   <= cmd_prot;
        pwdata  <= cmd_wdata;
        pstrb   <= cmd_write ? cmd_strb : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester (NSLV=4 main instance, NSLV=3 for decode errors).
module tb_apb_requester;

  logic        pclk, preset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic [2:0]  pprot;
  logic [3:0]  pstrb;
  logic        pready, pslverr;

  logic        c3_valid, c3_ready, c3_write;
  logic [31:0] c3_addr, c3_wdata;
  logic [3:0]  c3_strb;
  logic [2:0]  c3_prot;
  logic        c3_rsp_valid, c3_rsp_err;
  logic [31:0] c3_rsp_rdata;
  logic [2:0]  c3_psel;
  logic        c3_penable, c3_pwrite;
  logic [31:0] c3_paddr, c3_pwdata, c3_prdata;
  logic [2:0]  c3_pprot;
  logic [3:0]  c3_pstrb;
  logic        c3_pready, c3_pslverr;

  int checks = 0;
  int failures = 0;

  apb_requester #(
    .ADDR_W(32), .DATA_W(32), .NSLV(4), .SLV_LSB(28), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite), .pprot(pprot),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_requester #(
    .ADDR_W(32), .DATA_W(32), .NSLV(3), .SLV_LSB(28), .TIMEOUT(16)
  ) dut3 (
    .pclk(pclk), .preset(preset),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_addr(c3_addr),
    .cmd_write(c3_write), .cmd_wdata(c3_wdata), .cmd_strb(c3_strb), .cmd_prot(c3_prot),
    .rsp_valid(c3_rsp_valid), .rsp_rdata(c3_rsp_rdata), .rsp_err(c3_rsp_err),
    .psel(c3_psel), .penable(c3_penable), .paddr(c3_paddr), .pwrite(c3_pwrite), .pprot(c3_pprot),
    .pwdata(c3_pwdata), .pstrb(c3_pstrb), .prdata(c3_prdata), .pready(c3_pready),
    .pslverr(c3_pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    preset = 1'b0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    prdata = '0; pready = 0; pslverr = 0;
    c3_valid = 0; c3_write = 0; c3_addr = '0; c3_wdata = '0; c3_strb = '0; c3_prot = '0;
    c3_prdata = '0; c3_pready = 0; c3_pslverr = 0;

    // Reset state
    #1;
    check("rst_apb", {psel, penable, pwrite, pprot, pstrb}, 64'd0);
    check("rst_bus", {paddr, pwdata}, 64'd0);
    check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("rst_ready", cmd_ready, 64'd0);
    @(negedge pclk);
    @(negedge pclk);
    preset = 1'b1;

    // Read, zero wait states
    cmd_valid = 1; cmd_addr = 32'h1000_0004; cmd_write = 0; cmd_strb = 4'hF; cmd_prot = 3'b011;
    pready = 1; prdata = 32'hDEAD_BEEF;
    #1 check("rd_ready", cmd_ready, 64'd1);
    @(negedge pclk);
    cmd_valid = 0;
    check("rd_setup", {psel, penable, pstrb, pwrite}, {4'b0010, 1'b0, 4'b0000, 1'b0});
    check("rd_paddr", {pprot, paddr}, {3'b011, 32'h1000_0004});
    @(negedge pclk);
    check("rd_access", {psel, penable, rsp_valid}, {4'b0010, 1'b1, 1'b0});
    @(negedge pclk);
    check("rd_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hDEAD_BEEF});
    check("rd_idle", {psel, penable}, 64'd0);
    @(negedge pclk);
    check("rd_pulse", rsp_valid, 64'd0);

    // Write, three wait states, slave error
    cmd_valid = 1; cmd_addr = 32'h3000_0010; cmd_write = 1; cmd_wdata = 32'h1234_5678;
    cmd_strb = 4'b0101; cmd_prot = 3'b000; pready = 0; prdata = 32'hCAFE_F00D;
    @(negedge pclk);
    cmd_valid = 0;
    check("wr_setup", {psel, penable, pwrite, pstrb}, {4'b1000, 1'b0, 1'b1, 4'b0101});
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check("wr_hold", {psel, penable, pwrite, pstrb, rsp_valid, cmd_ready},
            {4'b1000, 1'b1, 1'b1, 4'b0101, 1'b0, 1'b0});
      check("wr_bus", {paddr, pwdata}, {32'h3000_0010, 32'h1234_5678});
      if (i == 3) begin
        pready = 1; pslverr = 1;
      end
    end
    @(negedge pclk);
    pslverr = 0;
    check("wr_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    check("wr_idle", {psel, penable}, 64'd0);

    // Back-to-back: read then write without an IDLE cycle
    cmd_valid = 1; cmd_addr = 32'h0000_0008; cmd_write = 0; cmd_strb = 4'hF;
    pready = 1; prdata = 32'hAAAA_0001;
    @(negedge pclk);
    check("b2b_setup1", {psel, penable, cmd_ready}, {4'b0001, 1'b0, 1'b0});
    cmd_addr = 32'h2000_0000; cmd_write = 1; cmd_wdata = 32'h55;
    @(negedge pclk);
    check("b2b_access1", {psel, penable, cmd_ready}, {4'b0001, 1'b1, 1'b1});
    @(negedge pclk);
    cmd_valid = 0;
    check("b2b_setup2", {psel, penable, paddr}, {4'b0100, 1'b0, 32'h2000_0000});
    check("b2b_rsp1", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'hAAAA_0001});
    @(negedge pclk);
    check("b2b_access2", {psel, penable, rsp_valid}, {4'b0100, 1'b1, 1'b0});
    @(negedge pclk);
    check("b2b_rsp2", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0});
    check("b2b_idle", {psel, penable}, 64'd0);

    // Decode error on the three-completer instance
    c3_valid = 1; c3_addr = 32'h3000_0000; c3_pready = 1; c3_prdata = 32'h1111_2222;
    #1 check("derr_ready", c3_ready, 64'd1);
    @(negedge pclk);
    c3_valid = 0;
    check("derr_state", {c3_psel, c3_penable, c3_rsp_valid, c3_ready}, 64'd0);
    @(negedge pclk);
    check("derr_rsp", {c3_rsp_valid, c3_rsp_err, c3_rsp_rdata, c3_psel}, {1'b1, 1'b1, 32'h0, 3'b000});
    @(negedge pclk);
    check("derr_after", {c3_rsp_valid, c3_ready}, {1'b0, 1'b1});

    // Asynchronous reset in the middle of ACCESS
    cmd_valid = 1; cmd_addr = 32'h0000_0000; cmd_write = 0; pready = 0;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    check("arst_pre", {psel, penable}, {4'b0001, 1'b1});
    #2 preset = 0;
    #1 check("arst_now", {psel, penable, rsp_valid, cmd_ready}, 64'd0);
    pready = 1;
    @(negedge pclk);
    @(negedge pclk);
    preset = 1;
    #1 check("arst_ready", cmd_ready, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge pclk);
      check("arst_norsp", {rsp_valid, psel, penable}, 64'd0);
    end

`ifdef APB_TIMEOUT_EN
    // ACCESS abandoned after 16 cycles without pready
    cmd_valid = 1; cmd_addr = 32'h1000_0000; cmd_write = 0; pready = 0; prdata = 32'h1234;
    @(negedge pclk);
    cmd_valid = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge pclk);
      check("to_wait", {psel, penable, rsp_valid}, {4'b0010, 1'b1, 1'b0});
    end
    @(negedge pclk);
    check("to_drop", {psel, penable}, 64'd0);
    check("to_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b1, 32'h0});
    @(negedge pclk);
`else
    // Without the limit, ACCESS waits as long as pready stays low
    cmd_valid = 1; cmd_addr = 32'h1000_0000; cmd_write = 0; pready = 0; prdata = 32'h600D_CAFE;
    @(negedge pclk);
    cmd_valid = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      check("nto_wait", {psel, penable, rsp_valid}, {4'b0010, 1'b1, 1'b0});
    end
    pready = 1;
    @(negedge pclk);
    check("nto_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h600D_CAFE});
    @(negedge pclk);
`endif

    // Normal transfer afterwards
    cmd_valid = 1; cmd_addr = 32'h1000_0000; cmd_write = 0; pready = 1; prdata = 32'h0BAD_F00D;
    @(negedge pclk);
    cmd_valid = 0;
    @(negedge pclk);
    @(negedge pclk);
    check("post_rsp", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, 1'b0, 32'h0BAD_F00D});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
